// File: rtl/dbg_uart_streamer.sv
// dbg_uart_streamer: captures a snapshot of CPU debug state on a trigger and
// streams it to a byte-wide UART transmitter as a fixed frame:
//   A5, status, pc hi/lo, sp hi/lo, AF hi/lo, BC hi/lo, DE hi/lo, HL hi/lo, opcode
// Optional feature macro: DBG_STREAM_CHECKSUM_EN appends a 16th byte chosen so
// that bytes 1..15 sum to zero modulo 256.
// Triggers arriving while a frame is in flight are counted (saturating) in
// drop_count and otherwise ignored.
module dbg_uart_streamer (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic [15:0] dbg_pc,
  input  logic [15:0] dbg_sp,
  input  logic [15:0] dbg_AF,
  input  logic [15:0] dbg_BC,
  input  logic [15:0] dbg_DE,
  input  logic [15:0] dbg_HL,
  input  logic [7:0]  dbg_last_opcode,
  input  logic [5:0]  dbg_stage,
  input  logic        dbg_halted,
  input  logic        dbg_instruction_retired,
  input  logic        is_transmitting,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic [7:0]  drop_count
);

`ifdef DBG_STREAM_CHECKSUM_EN
  localparam int unsigned NBYTES = 16;
`else
  localparam int unsigned NBYTES = 15;
`endif
  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] sp;
    logic [15:0] af;
    logic [15:0] bc;
    logic [15:0] de;
    logic [15:0] hl;
    logic [7:0]  opcode;
    logic [5:0]  stage;
    logic        halted;
    logic        retired;
  } snap_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  snap_t      snap_q, snap_d;
  logic       transmit_q, transmit_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       busy_q, busy_d;
  logic [7:0] drop_q, drop_d;

  function automatic logic [7:0] status_byte(input snap_t s);
    return {s.halted, s.retired, s.stage};
  endfunction

`ifdef DBG_STREAM_CHECKSUM_EN
  // Two's complement of the byte sum over status..opcode (8-bit wraparound).
  function automatic logic [7:0] checksum(input snap_t s);
    logic [7:0] sum;
    sum = status_byte(s)
        + s.pc[15:8] + s.pc[7:0] + s.sp[15:8] + s.sp[7:0]
        + s.af[15:8] + s.af[7:0] + s.bc[15:8] + s.bc[7:0]
        + s.de[15:8] + s.de[7:0] + s.hl[15:8] + s.hl[7:0]
        + s.opcode;
    return 8'h00 - sum;
  endfunction
`endif

  function automatic logic [7:0] frame_byte(input snap_t s, input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'hA5;
      4'd1:    b = status_byte(s);
      4'd2:    b = s.pc[15:8];
      4'd3:    b = s.pc[7:0];
      4'd4:    b = s.sp[15:8];
      4'd5:    b = s.sp[7:0];
      4'd6:    b = s.af[15:8];
      4'd7:    b = s.af[7:0];
      4'd8:    b = s.bc[15:8];
      4'd9:    b = s.bc[7:0];
      4'd10:   b = s.de[15:8];
      4'd11:   b = s.de[7:0];
      4'd12:   b = s.hl[15:8];
      4'd13:   b = s.hl[7:0];
      4'd14:   b = s.opcode;
`ifdef DBG_STREAM_CHECKSUM_EN
      4'd15:   b = checksum(s);
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Next-state logic: frame sequencing, snapshot capture, drop counting.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    drop_d     = drop_q;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          snap_d = '{pc: dbg_pc, sp: dbg_sp, af: dbg_AF, bc: dbg_BC,
                     de: dbg_DE, hl: dbg_HL, opcode: dbg_last_opcode,
                     stage: dbg_stage, halted: dbg_halted,
                     retired: dbg_instruction_retired};
          idx_d   = 4'd0;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!is_transmitting) begin
          transmit_d = 1'b1;
          tx_byte_d  = frame_byte(snap_q, idx_q);
          state_d    = ST_HOLD;
        end else begin
          state_d = ST_SEND;
        end
      end
      // The UART raises its busy flag a cycle after the pulse; ignore it here.
      ST_HOLD: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!is_transmitting) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Any trigger outside IDLE (including the final WAIT cycle) is dropped.
    if (trigger && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 4'd0;
      snap_q     <= '0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      busy_q     <= 1'b0;
      drop_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  assign transmit   = transmit_q;
  assign tx_byte    = tx_byte_q;
  assign busy       = busy_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_dbg_uart_streamer.sv
// Self-checking bench for dbg_uart_streamer: table of frame vectors plus
// directed sequences for drop counting, back-pressure, reset and the
// end-of-frame trigger boundary. A small UART model stays busy for 10 cycles
// after each transmit pulse and records every byte sent.
module tb_dbg_uart_streamer;

`ifdef DBG_STREAM_CHECKSUM_EN
  localparam int NB = 16;
`else
  localparam int NB = 15;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0;
  logic [15:0] dbg_pc = '0, dbg_sp = '0, dbg_AF = '0, dbg_BC = '0, dbg_DE = '0, dbg_HL = '0;
  logic [7:0]  dbg_last_opcode = '0;
  logic [5:0]  dbg_stage = '0;
  logic        dbg_halted = 1'b0, dbg_instruction_retired = 1'b0;
  logic        is_transmitting;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        busy;
  logic [7:0]  drop_count;

  logic        uart_busy_m = 1'b0;
  int          uart_cnt = 0;
  logic        force_busy = 1'b0;
  logic        prev_tx = 1'b0;
  logic [7:0]  rx_q[$];

  int checks = 0;
  int errors = 0;

  assign is_transmitting = uart_busy_m | force_busy;

  always #5 clk = ~clk;

  dbg_uart_streamer dut (
    .clk(clk), .rst(rst), .trigger(trigger),
    .dbg_pc(dbg_pc), .dbg_sp(dbg_sp), .dbg_AF(dbg_AF), .dbg_BC(dbg_BC),
    .dbg_DE(dbg_DE), .dbg_HL(dbg_HL), .dbg_last_opcode(dbg_last_opcode),
    .dbg_stage(dbg_stage), .dbg_halted(dbg_halted),
    .dbg_instruction_retired(dbg_instruction_retired),
    .is_transmitting(is_transmitting), .transmit(transmit), .tx_byte(tx_byte),
    .busy(busy), .drop_count(drop_count)
  );

  // UART model: records bytes, busy for 10 cycles per pulse, flags double pulses.
  always @(negedge clk) begin
    if (transmit) begin
      rx_q.push_back(tx_byte);
      checks++;
      if (prev_tx) begin
        errors++;
        $display("FAIL tx_double_pulse: transmit high two cycles in a row (byte %0h)", tx_byte);
      end
      uart_cnt = 10;
      uart_busy_m = 1'b1;
    end else if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) uart_busy_m = 1'b0;
    end
    prev_tx = transmit;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [15:0]  pc, sp, af, bc, de, hl;
    logic [7:0]   op;
    logic [5:0]   stage;
    logic         halted, retired, scramble;
    logic [127:0] exp;   // 16 bytes, byte 0 in the top bits; byte 15 = checksum
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input logic [127:0] e, input int i);
    return e[127 - 8*i -: 8];
  endfunction

  task automatic drive_vec(input vec_t v, input logic inv);
    dbg_pc = inv ? ~v.pc : v.pc;   dbg_sp = inv ? ~v.sp : v.sp;
    dbg_AF = inv ? ~v.af : v.af;   dbg_BC = inv ? ~v.bc : v.bc;
    dbg_DE = inv ? ~v.de : v.de;   dbg_HL = inv ? ~v.hl : v.hl;
    dbg_last_opcode = inv ? ~v.op : v.op;
    dbg_stage = inv ? ~v.stage : v.stage;
    dbg_halted = inv ? ~v.halted : v.halted;
    dbg_instruction_retired = inv ? ~v.retired : v.retired;
  endtask

  task automatic wait_rx(input string name, input int n, input int budget);
    for (int c = 0; c < budget && rx_q.size() < n; c++) step();
    chk(name, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int c = 0; c < budget && (busy || is_transmitting); c++) step();
    chk(name, 32'(!busy && !is_transmitting), 32'd1);
  endtask

  task automatic check_frame(input string name, input vec_t v);
    logic [7:0] got;
    for (int j = 0; j < NB; j++) begin
      got = (j < rx_q.size()) ? rx_q[j] : 8'hxx;
      chk($sformatf("%s_byte%0d", name, j), 32'(got), 32'(exp_byte(v.exp, j)));
    end
  endtask

  // Pulse trigger for one edge and check the first-byte latency.
  task automatic fire_and_check_latency(input string name, input vec_t v, input logic scramble);
    drive_vec(v, 1'b0);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    if (scramble) drive_vec(v, 1'b1);
    chk({name, "_busy_after_trig"}, 32'(busy), 32'd1);
    chk({name, "_no_tx_yet"}, 32'(transmit), 32'd0);
    step();
    chk({name, "_first_tx"}, 32'(transmit), 32'd1);
    chk({name, "_first_byte"}, 32'(tx_byte), 32'hA5);
  endtask

  initial begin
    logic [7:0] d0;
    logic       ok;

    vecs[0] = '{pc:16'h0150, sp:16'hFFFE, af:16'h01B0, bc:16'h0013, de:16'h00D8, hl:16'h014D,
                op:8'hC3, stage:6'h05, halted:1'b0, retired:1'b1, scramble:1'b0,
                exp:{8'hA5,8'h45,8'h01,8'h50,8'hFF,8'hFE,8'h01,8'hB0,
                     8'h00,8'h13,8'h00,8'hD8,8'h01,8'h4D,8'hC3,8'hC0}};
    vecs[1] = vecs[0];
    vecs[1].scramble = 1'b1;
    vecs[2] = '{pc:16'h1234, sp:16'hABCD, af:16'h0000, bc:16'hFFFF, de:16'h8001, hl:16'h7F80,
                op:8'h76, stage:6'h3F, halted:1'b1, retired:1'b0, scramble:1'b0,
                exp:{8'hA5,8'hBF,8'h12,8'h34,8'hAB,8'hCD,8'h00,8'h00,
                     8'hFF,8'hFF,8'h80,8'h01,8'h7F,8'h80,8'h76,8'h8F}};
    vecs[3] = '{pc:16'h0000, sp:16'h0000, af:16'h0000, bc:16'h0000, de:16'h0000, hl:16'h0000,
                op:8'h00, stage:6'h00, halted:1'b0, retired:1'b0, scramble:1'b0,
                exp:{8'hA5, {15{8'h00}}}};

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_transmit", 32'(transmit), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    rst = 1'b0;
    step();

    // Frame vectors (vecs[1] scrambles inputs right after the trigger)
    for (int i = 0; i < 4; i++) begin
      rx_q.delete();
      d0 = drop_count;
      fire_and_check_latency($sformatf("vec%0d", i), vecs[i], vecs[i].scramble);
      wait_rx($sformatf("vec%0d_rx_timeout", i), NB, 1000);
      wait_idle($sformatf("vec%0d_idle_timeout", i), 200);
      check_frame($sformatf("vec%0d", i), vecs[i]);
      chk($sformatf("vec%0d_drop_same", i), 32'(drop_count), 32'(d0));
      chk($sformatf("vec%0d_tx_byte_held", i), 32'(tx_byte), 32'(exp_byte(vecs[i].exp, NB-1)));
      step();
    end

    // Drop counting: 300 triggers while a frame is stalled mid-way
    rx_q.delete();
    drive_vec(vecs[2], 1'b0);
    trigger = 1'b1; step(); trigger = 1'b0;
    wait_rx("drop_rx1_timeout", 1, 100);
    force_busy = 1'b1;
    trigger = 1'b1;
    repeat (300) step();
    trigger = 1'b0;
    chk("drop_saturated", 32'(drop_count), 32'd255);
    chk("drop_busy_mid", 32'(busy), 32'd1);
    force_busy = 1'b0;
    wait_rx("drop_rx_timeout", NB, 1000);
    wait_idle("drop_idle_timeout", 200);
    chk("drop_busy_fell", 32'(busy), 32'd0);
    repeat (50) step();
    chk("drop_one_frame", 32'(rx_q.size()), 32'(NB));
    check_frame("drop", vecs[2]);

    // Back-pressure: UART busy for 50 cycles after the trigger
    rx_q.delete();
    force_busy = 1'b1;
    drive_vec(vecs[0], 1'b0);
    trigger = 1'b1; step(); trigger = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (transmit) ok = 1'b0;
      step();
    end
    chk("bp_no_tx_while_busy", 32'(ok), 32'd1);
    chk("bp_still_no_tx", 32'(transmit), 32'd0);
    force_busy = 1'b0;
    step();
    chk("bp_tx_after_release", 32'(transmit), 32'd1);
    chk("bp_byte", 32'(tx_byte), 32'hA5);
    step();
    chk("bp_single_pulse", 32'(transmit), 32'd0);
    wait_rx("bp_rx_timeout", NB, 1000);
    wait_idle("bp_idle_timeout", 200);
    check_frame("bp", vecs[0]);

    // Reset mid-frame after byte 5
    rx_q.delete();
    drive_vec(vecs[2], 1'b0);
    trigger = 1'b1; step(); trigger = 1'b0;
    wait_rx("rstmid_rx5_timeout", 5, 500);
    rst = 1'b1;
    step();
    chk("rstmid_transmit", 32'(transmit), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_drop", 32'(drop_count), 32'd0);
    chk("rstmid_tx_byte", 32'(tx_byte), 32'h00);
    rst = 1'b0;
    wait_idle("rstmid_uart_idle", 100);
    repeat (30) step();
    chk("rstmid_no_more_bytes", 32'(rx_q.size()), 32'd5);
    rx_q.delete();
    fire_and_check_latency("rstmid_new", vecs[0], 1'b0);
    wait_rx("rstmid_new_rx_timeout", NB, 1000);
    wait_idle("rstmid_new_idle_timeout", 200);
    check_frame("rstmid_new", vecs[0]);

    // Boundary: trigger in the cycle WAIT finishes the last byte
    rx_q.delete();
    drive_vec(vecs[0], 1'b0);
    trigger = 1'b1; step(); trigger = 1'b0;
    wait_rx("bnd_rx_timeout", NB, 1000);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (!is_transmitting) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bnd_uart_fall_timeout", 32'(ok), 32'd1);
    chk("bnd_busy_before", 32'(busy), 32'd1);
    d0 = drop_count;
    trigger = 1'b1;
    @(posedge clk);
    #1;
    trigger = 1'b0;
    chk("bnd_busy_after", 32'(busy), 32'd0);
    chk("bnd_drop_inc", 32'(drop_count), 32'(d0) + 32'd1);
    repeat (30) step();
    chk("bnd_no_new_frame_busy", 32'(busy), 32'd0);
    chk("bnd_no_new_frame_bytes", 32'(rx_q.size()), 32'(NB));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbg_uart_streamer.md
DBG_UART_STREAMER -- requirements
Module: dbg_uart_streamer

Interface
REQ-001 SHALL have: clk  in  1  single system clock; all logic on posedge clk.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: trigger  in  1  snapshot request, sampled every cycle (e.g. instruction retired).
REQ-004 SHALL have: dbg_pc, dbg_sp, dbg_AF, dbg_BC, dbg_DE, dbg_HL  in  16 each  CPU state to capture.
REQ-005 SHALL have: dbg_last_opcode  in  8; dbg_stage  in  6; dbg_halted  in  1; dbg_instruction_retired  in  1.
REQ-006 SHALL have: is_transmitting  in  1  UART transmitter busy.
REQ-007 SHALL have: transmit  out  1  one-cycle UART start pulse; tx_byte  out  8  byte to send.
REQ-008 SHALL have: busy  out  1  frame in progress; drop_count  out  8  triggers ignored while busy.

Function
REQ-009 SHALL capture all dbg_* inputs into a snapshot register on the edge where trigger=1 in IDLE; the frame SHALL use only the snapshot.
REQ-010 SHALL emit the frame in this order: 0xA5 (sync); status {dbg_halted, dbg_instruction_retired, dbg_stage[5:0]}; pc hi, pc lo; sp hi, sp lo; AF hi, AF lo; BC hi, BC lo; DE hi, DE lo; HL hi, HL lo; opcode. Total 15 bytes, plus optional checksum (REQ-021).
REQ-011 SHALL implement states IDLE, SEND, HOLD, WAIT with a byte index counter 0..N-1.
REQ-012 IDLE: on trigger, capture, set index=0, go SEND; otherwise stay.
REQ-013 SEND: if is_transmitting=0, assert transmit for exactly one cycle with tx_byte=frame[index], go HOLD; else stay with transmit=0.
REQ-014 HOLD: one-cycle guard covering the UART busy-flag latency; transmit=0; go WAIT.
REQ-015 WAIT: when is_transmitting=0, go IDLE if index=N-1, else increment index and go SEND.
REQ-016 Latency: trigger at edge k with UART idle SHALL produce transmit=1 during the cycle after edge k+1; consecutive bytes SHALL be separated only by UART busy time plus 2 cycles.
REQ-017 tx_byte SHALL hold its value from the transmit pulse until the next SEND; transmit SHALL never be high two cycles in a row.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 trigger=1 in any state other than IDLE, including the cycle in which WAIT returns to IDLE, SHALL be dropped, leaving the snapshot unchanged and incrementing drop_count, which saturates at 255.

Reset
REQ-020 rst=1 at any clock edge, including mid-frame, SHALL force state IDLE, index 0, transmit=0, tx_byte=0x00, busy=0, drop_count=0, snapshot=0. No further bytes of an aborted frame SHALL be sent; a byte already inside the UART is left to complete.

Configuration
REQ-021 With macro DBG_STREAM_CHECKSUM_EN defined, N SHALL be 16, and byte 15 SHALL equal the two's complement of the mod-256 sum of bytes 1..14, so that bytes 1..15 sum to 0x00.
REQ-022 Without DBG_STREAM_CHECKSUM_EN, N SHALL be 15, and no checksum logic or extra byte SHALL exist.

Verification
REQ-023 Basic frame: UART model busy for 10 cycles after each pulse; pc=0x0150, sp=0xFFFE, AF=0x01B0, BC=0x0013, DE=0x00D8, HL=0x014D, opcode=0xC3, stage=0x05, halted=0, retired=1, one trigger -> bytes A5 45 01 50 FF FE 01 B0 00 13 00 D8 01 4D C3; with checksum enabled, followed by C0.
REQ-024 Snapshot stability: same trigger, then change all dbg_* inputs on the next cycle -> transmitted bytes are still identical to REQ-023.
REQ-025 Drop counting: 300 trigger pulses issued during one frame -> drop_count=255 (saturated); exactly one frame is sent; busy falls after the last byte.
REQ-026 Back-pressure: is_transmitting held at 1 for 50 cycles after a trigger -> transmit stays 0 throughout, then pulses once in the cycle after is_transmitting falls.
REQ-027 Reset mid-frame: rst asserted after byte 5 -> transmit=0 and busy=0 from the next cycle; a new trigger afterwards starts a fresh frame with 0xA5.
REQ-028 Boundary: trigger in the same cycle that WAIT completes the last byte -> drop_count increments by 1 and no new frame starts.
